// File: rtl/serial_comparator.sv
// Digit-serial magnitude comparator: compares A against B, DIGIT bits per cycle, MSB-first,
// with early termination on the first differing digit and optional two's-complement mode.
module serial_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int D  = WIDTH / DIGIT;
    localparam int IW = (D > 1) ? $clog2(D) : 1;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_comparator: WIDTH must be >= 2 and a multiple of DIGIT (1..WIDTH)");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] msb_mask;
    logic [WIDTH-1:0] src_a, src_b;
    logic [DIGIT-1:0] dig_a, dig_b;
    logic [IW-1:0]    idx_q, idx_d;
    int               sel_k;
    logic             last_digit;
    logic             latch_en;
    logic             evaluate;
    logic             done_d, gt_d, eq_d, lt_d;

    // Flipping both MSBs turns a two's-complement compare into an unsigned one.
    assign msb_mask = {signed_mode, {(WIDTH-1){1'b0}}};

    // Digit 0 is judged straight from the inputs at the accept edge, so RUN
    // cycle idx compares digit idx+1; this keeps done at cycle k+1.
    always_comb begin
        if (state_q == IDLE) begin
            src_a = A ^ msb_mask;
            src_b = B ^ msb_mask;
            sel_k = 0;
        end else begin
            src_a = a_q;
            src_b = b_q;
            sel_k = int'(idx_q) + 1;
        end
        dig_a      = DIGIT'(src_a >> ((D - 1 - sel_k) * DIGIT));
        dig_b      = DIGIT'(src_b >> ((D - 1 - sel_k) * DIGIT));
        last_digit = (sel_k == D - 1);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        latch_en = 1'b0;
        evaluate = 1'b0;
        done_d   = 1'b0;
        gt_d     = gt;
        eq_d     = eq;
        lt_d     = lt;

        if (state_q == IDLE) begin
            if (start) begin
                latch_en = 1'b1;
                idx_d    = '0;
                evaluate = 1'b1;
            end
        end else begin
            evaluate = 1'b1;
        end

        if (evaluate) begin
            if (dig_a != dig_b) begin
                done_d  = 1'b1;
                gt_d    = (dig_a > dig_b);
                lt_d    = (dig_a < dig_b);
                eq_d    = 1'b0;
                state_d = IDLE;
            end else if (last_digit) begin
                done_d  = 1'b1;
                gt_d    = 1'b0;
                lt_d    = 1'b0;
                eq_d    = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = RUN;
                if (state_q == RUN) begin
                    idx_d = idx_q + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done    <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done    <= done_d;
            gt      <= gt_d;
            eq      <= eq_d;
            lt      <= lt_d;
            if (latch_en) begin
                a_q <= A ^ msb_mask;
                b_q <= B ^ msb_mask;
            end
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator (WIDTH=8, DIGIT=2): directed cases plus
// randomized compares against an integer-arithmetic reference model.
module tb_serial_comparator;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int D     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A, B;
    logic             busy, done, gt, eq, lt;

    int   vectors     = 0;
    int   miscompares = 0;
    logic pg, pe, pl;

    always #5 clk = ~clk;

    serial_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .A(A), .B(B), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result from integer compare; done cycle from the highest differing bit position.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         output int dc, output logic g, output logic e, output logic l);
        int         va, vb;
        logic [7:0] x;
        if (sm) begin
            va = int'($signed(a));
            vb = int'($signed(b));
        end else begin
            va = int'(a);
            vb = int'(b);
        end
        g  = (va > vb);
        e  = (va == vb);
        l  = (va < vb);
        x  = a ^ b;
        dc = D;
        for (int p = 0; p < WIDTH; p++) begin
            if (x[p]) dc = (WIDTH - 1 - p) / DIGIT + 1;
        end
    endtask

    // Called in cycle 0 (one time unit after an edge); returns in the done cycle.
    task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic sm, input int inj);
        int   dc;
        logic g, e, l;
        model(a, b, sm, dc, g, e, l);
        start       = 1'b1;
        A           = a;
        B           = b;
        signed_mode = sm;
        step();
        for (int c = 1; c <= dc; c++) begin
            chk($sformatf("busy a=%h b=%h s=%0d c%0d", a, b, sm, c), {7'd0, busy}, {7'd0, c < dc});
            chk($sformatf("done a=%h b=%h s=%0d c%0d", a, b, sm, c), {7'd0, done}, {7'd0, c == dc});
            if (c < dc) begin
                chk($sformatf("hold a=%h b=%h c%0d", a, b, c), {5'd0, gt, eq, lt}, {5'd0, pg, pe, pl});
                if (c == inj) begin
                    start       = 1'b1;
                    A           = 8'($urandom);
                    B           = 8'($urandom);
                    signed_mode = 1'($urandom);
                end else begin
                    start = 1'b0;
                end
                step();
            end else begin
                chk($sformatf("result a=%h b=%h s=%0d", a, b, sm), {5'd0, gt, eq, lt}, {5'd0, g, e, l});
            end
        end
        start = 1'b0;
        pg = g;
        pe = e;
        pl = l;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            step();
            chk("idle busy/done", {6'd0, busy, done}, 8'd0);
            chk("idle flags", {5'd0, gt, eq, lt}, {5'd0, pg, pe, pl});
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
        pg = 1'b0; pe = 1'b0; pl = 1'b0;
        step();
        step();
        chk("reset state", {3'd0, busy, done, gt, eq, lt}, 8'd0);
        rst = 1'b0;
        idle(1);

        run_cmp(8'hC3, 8'h43, 1'b0, 0);
        idle(1);
        run_cmp(8'hC3, 8'h43, 1'b1, 0);
        run_cmp(8'h5A, 8'h5A, 1'b0, 0);
        run_cmp(8'h5A, 8'h5A, 1'b1, 0);
        run_cmp(8'h12, 8'h13, 1'b0, 2);
        run_cmp(8'h01, 8'h00, 1'b0, 0);
        idle(2);

        // Reset in cycle 2 of a full-length compare.
        start = 1'b1; A = 8'h5A; B = 8'h5A; signed_mode = 1'b0;
        step();
        start = 1'b0;
        chk("pre-reset busy", {7'd0, busy}, 8'd1);
        step();
        rst = 1'b1;
        step();
        chk("mid reset outputs", {3'd0, busy, done, gt, eq, lt}, 8'd0);
        rst = 1'b0;
        pg = 1'b0; pe = 1'b0; pl = 1'b0;
        idle(5);
        run_cmp(8'h01, 8'h00, 1'b0, 0);

        for (int n = 0; n < 80; n++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            run_cmp(ra, rb, 1'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
